// File: rtl/imem_loader.sv
// imem_loader: streams a length-prefixed image into instruction memory and
// releases the processor only after the XOR checksum of the data verifies.
module imem_loader #(
    parameter int ADDR_WIDTH = 12,
    parameter int TIMEOUT    = 1000000
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  start,
    output logic                  imem_wen,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_data,
    output logic                  cpu_reset,
    output logic                  done,
    output logic                  error
);

    typedef enum logic [2:0] {
        LEN_HI,
        LEN_LO,
        DATA,
        CHECK,
        DONE,
        ERR
    } state_t;

    localparam logic [16:0]           MAX_WORDS = 17'(1 << ADDR_WIDTH);
    localparam logic [31:0]           IDLE_LAST = 32'(TIMEOUT - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);

    state_t      state;
    state_t      nxt;
    logic [7:0]  len_hi;
    logic [15:0] count;
    logic [15:0] wcnt;
    logic [1:0]  bidx;
    logic [23:0] part;
    logic [7:0]  acc;
    logic [31:0] idle;

    logic take;
    logic idle_out;
    logic last_byte;
    logic last_word;
    logic rearm;

    assign take      = in_valid & in_ready;
    assign idle_out  = (idle == IDLE_LAST);
    assign last_byte = (bidx == 2'd3);
    assign last_word = (wcnt == count - 16'd1);
    assign rearm     = start & ((state == DONE) | (state == ERR));

    // An accepted byte always wins over an idle timeout on the same cycle.
    always_comb begin
        nxt = state;
        unique case (state)
            LEN_HI: begin
                if (take) nxt = LEN_LO;
            end
            LEN_LO: begin
                if (take) begin
                    if ({1'b0, len_hi, in_data} > MAX_WORDS) nxt = ERR;
                    else if ({len_hi, in_data} == 16'd0)     nxt = CHECK;
                    else                                     nxt = DATA;
                end else if (idle_out) begin
                    nxt = ERR;
                end
            end
            DATA: begin
                if (take) begin
                    if (last_byte && last_word) nxt = CHECK;
                end else if (idle_out) begin
                    nxt = ERR;
                end
            end
            CHECK: begin
                if (take)          nxt = (in_data == acc) ? DONE : ERR;
                else if (idle_out) nxt = ERR;
            end
            DONE, ERR: begin
                if (start) nxt = LEN_HI;
            end
            default: nxt = ERR;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= LEN_HI;
            in_ready  <= 1'b1;
            cpu_reset <= 1'b1;
            done      <= 1'b0;
            error     <= 1'b0;
            imem_wen  <= 1'b0;
            imem_addr <= '0;
            imem_data <= '0;
            len_hi    <= '0;
            count     <= '0;
            wcnt      <= '0;
            bidx      <= '0;
            part      <= '0;
            acc       <= '0;
            idle      <= '0;
        end else begin
            state     <= nxt;
            in_ready  <= nxt inside {LEN_HI, LEN_LO, DATA, CHECK};
            cpu_reset <= (nxt != DONE);
            done      <= (nxt == DONE);
            error     <= (nxt == ERR);
            imem_wen  <= take && (state == DATA) && last_byte;

            if (take || state inside {LEN_HI, DONE, ERR})
                idle <= '0;
            else
                idle <= idle + 32'd1;

            // Address advances after its write cycle, wrapping silently.
            if (rearm) begin
                imem_addr <= '0;
                wcnt      <= '0;
                bidx      <= '0;
                acc       <= '0;
            end else if (imem_wen) begin
                imem_addr <= imem_addr + ADDR_ONE;
            end

            if (take) begin
                case (state)
                    LEN_HI: len_hi <= in_data;
                    LEN_LO: count  <= {len_hi, in_data};
                    DATA: begin
                        acc  <= acc ^ in_data;
                        bidx <= bidx + 2'd1;
                        if (last_byte) begin
                            imem_data <= {part, in_data};
                            wcnt      <= wcnt + 16'd1;
                        end else begin
                            part <= {part[15:0], in_data};
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed vector table plus hand-written sequences for
// timeout, full-size image with address wrap, and asynchronous reset.
module tb_imem_loader;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        start = 1'b0;
    logic        imem_wen;
    logic [11:0] imem_addr;
    logic [31:0] imem_data;
    logic        cpu_reset;
    logic        done;
    logic        error;

    imem_loader #(.ADDR_WIDTH(12), .TIMEOUT(16)) dut (
        .clock(clock),
        .reset(reset),
        .in_data(in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .start(start),
        .imem_wen(imem_wen),
        .imem_addr(imem_addr),
        .imem_data(imem_data),
        .cpu_reset(cpu_reset),
        .done(done),
        .error(error)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic        v;
        logic [7:0]  d;
        logic        s;
        logic        rdy;
        logic        wen;
        logic [11:0] a;
        logic [31:0] w;
        logic        cr;
        logic        dn;
        logic        er;
    } vec_t;

    int nvec = 0;
    int nbad = 0;

    // write capture, sampled on the falling edge
    logic [31:0] mem [0:4095];
    int          nwrites = 0;
    int          dbl = 0;
    logic [11:0] last_addr = '0;
    logic        prev_wen = 1'b0;

    always @(negedge clock) begin
        prev_wen <= imem_wen;
        if (imem_wen) begin
            mem[imem_addr] <= imem_data;
            last_addr      <= imem_addr;
            nwrites        <= nwrites + 1;
            if (prev_wen) dbl <= dbl + 1;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    function automatic logic [48:0] outs();
        return {in_ready, imem_wen, imem_addr, imem_data,
                cpu_reset, done, error};
    endfunction

    function automatic vec_t mk(logic v, logic [7:0] d, logic s,
                                logic rdy, logic wen, logic [11:0] a,
                                logic [31:0] w, logic cr, logic dn,
                                logic er);
        vec_t t;
        t = {v, d, s, rdy, wen, a, w, cr, dn, er};
        return t;
    endfunction

    function automatic logic [31:0] word_of(int i);
        logic [15:0] k;
        k = 16'(i);
        return {k ^ 16'h5A3C, ~k};
    endfunction

    task automatic send(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        @(negedge clock);
    endtask

    task automatic pulse_start();
        in_valid = 1'b0;
        start    = 1'b1;
        @(negedge clock);
        start    = 1'b0;
    endtask

    localparam logic [31:0] W0 = 32'hDEADBEEF;
    localparam logic [31:0] W1 = 32'h01020304;

    initial begin
        vec_t        tv[$];
        logic [7:0]  ck;
        logic [7:0]  b;
        logic [31:0] w;
        int          wbase;
        int          rdy_low;
        int          bad_words;

        ck = 8'hDE ^ 8'hAD ^ 8'hBE ^ 8'hEF ^ 8'h01 ^ 8'h02 ^ 8'h03 ^ 8'h04;

        // good image, then wrong checksum, oversize, empty image
        tv.push_back(mk(1, 8'h00, 0, 1, 0, 0, 0, 1, 0, 0));
        tv.push_back(mk(1, 8'h02, 0, 1, 0, 0, 0, 1, 0, 0));
        tv.push_back(mk(1, 8'hDE, 0, 1, 0, 0, 0, 1, 0, 0));
        tv.push_back(mk(1, 8'hAD, 0, 1, 0, 0, 0, 1, 0, 0));
        tv.push_back(mk(1, 8'hBE, 0, 1, 0, 0, 0, 1, 0, 0));
        tv.push_back(mk(1, 8'hEF, 0, 1, 1, 0, W0, 1, 0, 0));
        tv.push_back(mk(1, 8'h01, 0, 1, 0, 1, W0, 1, 0, 0));
        tv.push_back(mk(1, 8'h02, 0, 1, 0, 1, W0, 1, 0, 0));
        tv.push_back(mk(1, 8'h03, 0, 1, 0, 1, W0, 1, 0, 0));
        tv.push_back(mk(1, 8'h04, 0, 1, 1, 1, W1, 1, 0, 0));
        tv.push_back(mk(1, ck,    0, 0, 0, 2, W1, 0, 1, 0));
        tv.push_back(mk(0, 8'h00, 0, 0, 0, 2, W1, 0, 1, 0));
        tv.push_back(mk(1, 8'h55, 0, 0, 0, 2, W1, 0, 1, 0));
        tv.push_back(mk(0, 8'h00, 1, 1, 0, 0, W1, 1, 0, 0));
        tv.push_back(mk(1, 8'h00, 0, 1, 0, 0, W1, 1, 0, 0));
        tv.push_back(mk(1, 8'h02, 0, 1, 0, 0, W1, 1, 0, 0));
        tv.push_back(mk(1, 8'hDE, 0, 1, 0, 0, W1, 1, 0, 0));
        tv.push_back(mk(1, 8'hAD, 0, 1, 0, 0, W1, 1, 0, 0));
        tv.push_back(mk(1, 8'hBE, 0, 1, 0, 0, W1, 1, 0, 0));
        tv.push_back(mk(1, 8'hEF, 0, 1, 1, 0, W0, 1, 0, 0));
        tv.push_back(mk(1, 8'h01, 0, 1, 0, 1, W0, 1, 0, 0));
        tv.push_back(mk(1, 8'h02, 0, 1, 0, 1, W0, 1, 0, 0));
        tv.push_back(mk(1, 8'h03, 0, 1, 0, 1, W0, 1, 0, 0));
        tv.push_back(mk(1, 8'h04, 0, 1, 1, 1, W1, 1, 0, 0));
        tv.push_back(mk(1, 8'h00, 0, 0, 0, 2, W1, 1, 0, 1));
        tv.push_back(mk(1, ck,    0, 0, 0, 2, W1, 1, 0, 1));
        tv.push_back(mk(0, 8'h00, 1, 1, 0, 0, W1, 1, 0, 0));
        tv.push_back(mk(1, 8'h10, 0, 1, 0, 0, W1, 1, 0, 0));
        tv.push_back(mk(1, 8'h01, 0, 0, 0, 0, W1, 1, 0, 1));
        tv.push_back(mk(0, 8'h00, 1, 1, 0, 0, W1, 1, 0, 0));
        tv.push_back(mk(1, 8'h00, 0, 1, 0, 0, W1, 1, 0, 0));
        tv.push_back(mk(1, 8'h00, 0, 1, 0, 0, W1, 1, 0, 0));
        tv.push_back(mk(1, 8'h00, 0, 0, 0, 0, W1, 0, 1, 0));

        @(negedge clock);
        @(negedge clock);
        chk("reset_values", 64'(outs()), 64'({1'b1, 1'b0, 12'h0, 32'h0,
                                              1'b1, 1'b0, 1'b0}));
        reset = 1'b1;

        foreach (tv[i]) begin
            in_valid = tv[i].v;
            in_data  = tv[i].d;
            start    = tv[i].s;
            @(negedge clock);
            chk($sformatf("vec%0d", i), 64'(outs()),
                64'({tv[i].rdy, tv[i].wen, tv[i].a, tv[i].w,
                     tv[i].cr, tv[i].dn, tv[i].er}));
        end
        in_valid = 1'b0;
        start    = 1'b0;
        chk("table_writes", 64'(nwrites), 64'(4));

        // idle timeout: two data bytes, then 16 silent cycles
        pulse_start();
        send(8'h00);
        send(8'h01);
        send(8'hDE);
        send(8'hAD);
        in_valid = 1'b0;
        wbase = nwrites;
        for (int i = 1; i <= 15; i++) begin
            @(negedge clock);
            chk($sformatf("tmo_idle%0d", i), 64'(error), 64'(0));
        end
        @(negedge clock);
        chk("tmo_fire", 64'({error, cpu_reset, in_ready}), 64'(3'b110));
        chk("tmo_no_write", 64'(nwrites - wbase), 64'(0));

        // a byte on the expiring cycle wins, and the count restarts
        pulse_start();
        send(8'h00);
        in_valid = 1'b0;
        repeat (15) @(negedge clock);
        send(8'h01);
        in_valid = 1'b0;
        chk("accept_wins", 64'({error, in_ready}), 64'(2'b01));
        repeat (15) @(negedge clock);
        chk("tmo_restart_early", 64'(error), 64'(0));
        @(negedge clock);
        chk("tmo_restart_fire", 64'(error), 64'(1));

        // full-size image, one byte per cycle
        pulse_start();
        send(8'h10);
        send(8'h00);
        ck = 8'h00;
        rdy_low = 0;
        wbase = nwrites;
        for (int i = 0; i < 4096; i++) begin
            w = word_of(i);
            for (int j = 0; j < 4; j++) begin
                b = w[31 - 8*j -: 8];
                if (!in_ready) rdy_low++;
                send(b);
                ck = ck ^ b;
            end
        end
        send(ck);
        in_valid = 1'b0;
        chk("full_ready", 64'(rdy_low), 64'(0));
        chk("full_done", 64'({done, cpu_reset, error, in_ready}),
            64'(4'b1000));
        chk("full_writes", 64'(nwrites - wbase), 64'(4096));
        chk("full_last_addr", 64'(last_addr), 64'(12'hFFF));
        chk("full_addr_wrap", 64'(imem_addr), 64'(0));
        chk("wen_one_cycle", 64'(dbl), 64'(0));
        bad_words = 0;
        for (int i = 0; i < 4096; i++)
            if (mem[i] !== word_of(i)) bad_words++;
        chk("full_contents", 64'(bad_words), 64'(0));

        // reset asserted part-way through word 100
        pulse_start();
        send(8'h10);
        send(8'h00);
        wbase = nwrites;
        for (int i = 0; i < 100; i++) begin
            w = word_of(i);
            for (int j = 0; j < 4; j++) send(w[31 - 8*j -: 8]);
        end
        send(8'hAA);
        send(8'hBB);
        in_valid = 1'b0;
        chk("mid_writes", 64'(nwrites - wbase), 64'(100));
        #2 reset = 1'b0;
        #1;
        chk("mid_async_reset", 64'(outs()), 64'({1'b1, 1'b0, 12'h0, 32'h0,
                                                 1'b1, 1'b0, 1'b0}));
        repeat (3) @(negedge clock);
        reset = 1'b1;
        chk("mid_no_more_writes", 64'(nwrites - wbase), 64'(100));

        // restart from LEN_HI after release
        wbase = nwrites;
        send(8'h00);
        send(8'h01);
        send(8'h11);
        send(8'h22);
        send(8'h33);
        send(8'h44);
        send(8'h11 ^ 8'h22 ^ 8'h33 ^ 8'h44);
        in_valid = 1'b0;
        @(negedge clock);
        chk("restart_done", 64'({done, cpu_reset, error}), 64'(3'b100));
        chk("restart_write", 64'({32'(nwrites - wbase), 20'h0, last_addr}),
            64'({32'd1, 20'h0, 12'h000}));
        chk("restart_data", 64'(mem[0]), 64'(32'h11223344));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
